// File: rtl/vlib_psum_accum_ctrl_pkg.sv
// Shared types and width helpers for the channel-tiled partial-sum accumulator.
package vlib_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } accum_state_e;

  function automatic int tree_w(input int atomic_c, input int bitwidth);
    return bitwidth + $clog2(atomic_c);
  endfunction

  function automatic int acc_w(input int atomic_c, input int bitwidth, input int max_slices);
    return tree_w(atomic_c, bitwidth) + $clog2(max_slices) + 1;
  endfunction

  // Clamp a sign-extended value into the signed range of an out_width-bit result.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input int out_width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/vlib_psum_accum_ctrl_if.sv
// Operand stream and result handshake between the feeder, the accumulator and the psum writer.
interface vlib_psum_accum_ctrl_if #(
  parameter int ATOMIC_C  = 8,
  parameter int BITWIDTH  = 8,
  parameter int OUT_WIDTH = 16
);
  logic                         IN_VALID;
  logic                         IN_READY;
  logic [ATOMIC_C*BITWIDTH-1:0] IN;
  logic                         OUT_VALID;
  logic                         OUT_READY;
  logic [OUT_WIDTH-1:0]         RES;

  modport master (
    output IN_VALID, IN, OUT_READY,
    input  IN_READY, OUT_VALID, RES
  );

  modport slave (
    input  IN_VALID, IN, OUT_READY,
    output IN_READY, OUT_VALID, RES
  );
endinterface

// File: rtl/vlib_psum_accum_ctrl_adder_tree.sv
// Combinational balanced adder tree: sums ATOMIC_C signed lanes, lane 0 at the LSBs.
module VLIB_adder_tree #(
  parameter  int ATOMIC_C = 8,
  parameter  int BITWIDTH = 8,
  localparam int LEVELS   = $clog2(ATOMIC_C),
  localparam int TREE_W   = BITWIDTH + LEVELS
) (
  input  logic [ATOMIC_C*BITWIDTH-1:0] IN,
  output logic signed [TREE_W-1:0]     SUM
);

  // Each level halves the node count; full tree width is used throughout so no level can overflow.
  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    localparam int N = ATOMIC_C >> l;
    logic signed [TREE_W-1:0] v [N];
    if (l == 0) begin : leaf
      for (genvar i = 0; i < N; i++) begin : lane
        assign v[i] = {{(TREE_W-BITWIDTH){IN[i*BITWIDTH+BITWIDTH-1]}}, IN[i*BITWIDTH +: BITWIDTH]};
      end
    end else begin : node
      for (genvar i = 0; i < N; i++) begin : pair
        assign v[i] = lvl[l-1].v[2*i] + lvl[l-1].v[2*i+1];
      end
    end
  end

  assign SUM = lvl[LEVELS].v[0];

endmodule

// File: rtl/vlib_psum_accum_ctrl.sv
// Streams NSLICE operand beats through one adder tree and emits the accumulated partial sum.
// Optional ACCUM_SATURATE_EN clamps RES to the signed OUT_WIDTH range and raises SAT.
module vlib_psum_accum_ctrl
  import vlib_accum_pkg::*;
#(
  parameter  int ATOMIC_C   = 8,
  parameter  int BITWIDTH   = 8,
  parameter  int MAX_SLICES = 16,
  parameter  int OUT_WIDTH  = 16,
  localparam int NS_W       = $clog2(MAX_SLICES) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [NS_W-1:0]       CFG_NSLICE,
  input  logic                  CLR,
  vlib_psum_accum_ctrl_if.slave bus,
  output logic                  BUSY,
  output logic                  CFG_ERR,
  output logic                  SAT
);

  localparam int TREE_W = tree_w(ATOMIC_C, BITWIDTH);
  localparam int ACC_W  = acc_w(ATOMIC_C, BITWIDTH, MAX_SLICES);

  accum_state_e             state;
  accum_state_e             state_next;
  logic [NS_W-1:0]          nslice;
  logic [NS_W-1:0]          cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [TREE_W-1:0] tree_sum;
  logic [OUT_WIDTH-1:0]     res_q;
  logic [OUT_WIDTH-1:0]     res_d;
  logic                     cfg_err_q;
  logic                     nslice_legal;
  logic                     start_ok;
  logic                     beat;
  logic                     last_beat;

  VLIB_adder_tree #(
    .ATOMIC_C (ATOMIC_C),
    .BITWIDTH (BITWIDTH)
  ) u_tree (
    .IN  (bus.IN),
    .SUM (tree_sum)
  );

  assign nslice_legal = (CFG_NSLICE != '0) && (CFG_NSLICE <= NS_W'(MAX_SLICES));
  assign start_ok     = START && nslice_legal;
  assign beat         = (state == ACCUM) && bus.IN_VALID;
  assign last_beat    = beat && (cnt == nslice - NS_W'(1));
  assign acc_sum      = acc + {{(ACC_W-TREE_W){tree_sum[TREE_W-1]}}, tree_sum};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // CLR overrides whatever transition the current state would take.
  always_comb begin
    state_next    = state;
    bus.IN_READY  = 1'b0;
    bus.OUT_VALID = 1'b0;
    BUSY          = 1'b1;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (start_ok) state_next = ACCUM;
      end
      ACCUM: begin
        bus.IN_READY = 1'b1;
        if (last_beat) state_next = DONE;
      end
      DONE: begin
        bus.OUT_VALID = 1'b1;
        if (bus.OUT_READY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (CLR) state_next = IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc       <= '0;
      cnt       <= '0;
      nslice    <= '0;
      res_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (CLR) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              nslice <= CFG_NSLICE;
              acc    <= '0;
              cnt    <= '0;
            end else if (START) begin
              cfg_err_q <= 1'b1;
            end
          end
          ACCUM: begin
            if (beat) begin
              acc <= acc_sum;
              cnt <= cnt + NS_W'(1);
              if (last_beat) res_q <= res_d;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ACCUM_SATURATE_EN
  logic signed [63:0] acc_wide;
  logic signed [63:0] acc_clamped;
  logic               sat_d;
  logic               sat_q;

  always_comb begin
    acc_wide    = {{(64-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
    acc_clamped = sat_clamp(acc_wide, OUT_WIDTH);
    res_d       = acc_clamped[OUT_WIDTH-1:0];
    sat_d       = (acc_clamped != acc_wide);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sat_q <= 1'b0;
    end else if (last_beat && !CLR) begin
      sat_q <= sat_d;
    end
  end

  assign SAT = sat_q && (state == DONE);
`else
  assign res_d = acc_sum[OUT_WIDTH-1:0];
  assign SAT   = 1'b0;
`endif

  assign bus.RES = res_q;
  assign CFG_ERR = cfg_err_q;

endmodule

// File: tb/tb_vlib_psum_accum_ctrl.sv
// Self-checking bench for vlib_psum_accum_ctrl with OUT_WIDTH=12 so the wrap/clamp boundary is reachable.
module tb_vlib_psum_accum_ctrl;

  localparam int ATOMIC_C   = 8;
  localparam int BITWIDTH   = 8;
  localparam int MAX_SLICES = 16;
  localparam int OUT_WIDTH  = 12;
  localparam int NS_W       = $clog2(MAX_SLICES) + 1;
  localparam int NVEC       = 8;

  typedef struct {
    int nslice;
    int v0;
    int v1;
    int v2;
    int v3;
    int step;
    int gap;
    int exp_wrap;
    int exp_clamp;
    bit exp_sat;
  } vec_t;

  typedef struct {
    logic [OUT_WIDTH-1:0] res;
    logic                 sat;
  } exp_t;

  logic            CLK;
  logic            RST;
  logic            START;
  logic [NS_W-1:0] CFG_NSLICE;
  logic            CLR;
  logic            BUSY;
  logic            CFG_ERR;
  logic            SAT;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[NVEC];

  vlib_psum_accum_ctrl_if #(
    .ATOMIC_C (ATOMIC_C),
    .BITWIDTH (BITWIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) bus ();

  vlib_psum_accum_ctrl #(
    .ATOMIC_C  (ATOMIC_C),
    .BITWIDTH  (BITWIDTH),
    .MAX_SLICES(MAX_SLICES),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .CFG_NSLICE(CFG_NSLICE),
    .CLR       (CLR),
    .bus       (bus),
    .BUSY      (BUSY),
    .CFG_ERR   (CFG_ERR),
    .SAT       (SAT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [ATOMIC_C*BITWIDTH-1:0] packLanes(input int val, input int step);
    logic [ATOMIC_C*BITWIDTH-1:0] p;
    int x;
    p = '0;
    for (int i = 0; i < ATOMIC_C; i++) begin
      x = val + i * step;
      p[i*BITWIDTH +: BITWIDTH] = x[BITWIDTH-1:0];
    end
    return p;
  endfunction

  // Reference result for a full-precision sum, in the build's RES mode.
  function automatic int modelRes(input int sum);
    int hi;
    int lo;
    hi = (1 << (OUT_WIDTH - 1)) - 1;
    lo = -(1 << (OUT_WIDTH - 1));
`ifdef ACCUM_SATURATE_EN
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
`else
    if (hi < lo) return 0;
    return sum;
`endif
  endfunction

  function automatic bit modelSat(input int sum);
`ifdef ACCUM_SATURATE_EN
    return (sum > (1 << (OUT_WIDTH - 1)) - 1) || (sum < -(1 << (OUT_WIDTH - 1)));
`else
    return (sum != sum) ? 1'b1 : 1'b0;
`endif
  endfunction

  task automatic pushExpected(input int res, input bit sat);
    exp_t e;
    e.res = OUT_WIDTH'(res);
    e.sat = sat;
    sbq.push_back(e);
  endtask

  task automatic startJob(input int n);
    START      = 1'b1;
    CFG_NSLICE = NS_W'(n);
    tick();
    START      = 1'b0;
  endtask

  task automatic sendBeat(input int val, input int step, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      bus.IN_VALID = 1'b0;
      tick();
    end
    bus.IN_VALID = 1'b1;
    bus.IN       = packLanes(val, step);
    t = 0;
    while (!bus.IN_READY && t < 20) begin
      tick();
      t++;
    end
    if (!bus.IN_READY) checkOutput("in_ready_timeout", 0, 1);
    tick();
    bus.IN_VALID = 1'b0;
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while (BUSY && t < 40) begin
      tick();
      t++;
    end
    if (BUSY) checkOutput("idle_timeout", 1, 0);
  endtask

  function automatic int beatVal(input vec_t v, input int b);
    case (b)
      0:       return v.v0;
      1:       return v.v1;
      2:       return v.v2;
      default: return v.v3;
    endcase
  endfunction

  task automatic applyStimulus(input vec_t v);
    startJob(v.nslice);
    checkOutput("start_busy", int'(BUSY), 1);
    checkOutput("start_in_ready", int'(bus.IN_READY), 1);
    checkOutput("start_cfg_err", int'(CFG_ERR), 0);
    for (int b = 0; b < v.nslice; b++) begin
      if (b == v.nslice - 1) begin
`ifdef ACCUM_SATURATE_EN
        pushExpected(v.exp_clamp, v.exp_sat);
`else
        pushExpected(v.exp_wrap, 1'b0);
`endif
      end
      sendBeat(beatVal(v, b), v.step, (b > 0) ? v.gap : 0);
    end
    checkOutput("done_in_ready", int'(bus.IN_READY), 0);
    checkOutput("done_out_valid", int'(bus.OUT_VALID), 1);
    waitIdle();
  endtask

  // Scoreboard: every handshake on the result side consumes one expected entry.
  always @(negedge CLK) begin
    if (!RST && bus.OUT_VALID && bus.OUT_READY) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("res", int'(bus.RES), int'(mon_e.res));
        checkOutput("sat", int'(SAT), int'(mon_e.sat));
      end
    end
  end

  initial begin
    int exp56;

    vecs[0] = '{1,  1,    1,    1,    1,    0, 0, 8,     8,     1'b0};
    vecs[1] = '{4,  10,   -3,   127,  -128, 0, 1, 48,    48,    1'b0};
    vecs[2] = '{3,  -5,   0,    7,    7,    2, 0, 184,   184,   1'b0};
    vecs[3] = '{2,  -100, -50,  -50,  -50,  0, 2, -1200, -1200, 1'b0};
    vecs[4] = '{16, 127,  127,  127,  127,  0, 0, -128,  2047,  1'b1};
    vecs[5] = '{16, -128, -128, -128, -128, 0, 0, 0,     -2048, 1'b1};
    vecs[6] = '{2,  127,  127,  127,  127,  0, 0, 2032,  2032,  1'b0};
    vecs[7] = '{3,  127,  127,  2,    2,    0, 0, -2048, 2047,  1'b1};

    RST          = 1'b1;
    START        = 1'b0;
    CFG_NSLICE   = '0;
    CLR          = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN       = '0;
    bus.OUT_READY = 1'b1;

    tick();
    tick();
    checkOutput("rst_busy", int'(BUSY), 0);
    checkOutput("rst_in_ready", int'(bus.IN_READY), 0);
    checkOutput("rst_out_valid", int'(bus.OUT_VALID), 0);
    checkOutput("rst_res", int'(bus.RES), 0);
    checkOutput("rst_cfg_err", int'(CFG_ERR), 0);
    checkOutput("rst_sat", int'(SAT), 0);
    RST = 1'b0;
    tick();

    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vecs[k]);
      tick();
    end

    // Backpressure: result held, extra beats and START ignored while DONE waits.
    bus.OUT_READY = 1'b0;
    exp56 = modelRes(56);
    startJob(2);
    sendBeat(3, 0, 0);
    pushExpected(exp56, modelSat(56));
    sendBeat(4, 0, 0);
    for (int c = 0; c < 5; c++) begin
      bus.IN_VALID = 1'b1;
      bus.IN       = packLanes(50, 0);
      START        = 1'b1;
      CFG_NSLICE   = NS_W'(2);
      tick();
      checkOutput("hold_valid", int'(bus.OUT_VALID), 1);
      checkOutput("hold_res", int'(bus.RES), int'(OUT_WIDTH'(exp56)));
      checkOutput("hold_in_ready", int'(bus.IN_READY), 0);
    end
    bus.OUT_READY = 1'b1;
    tick();
    START        = 1'b0;
    bus.IN_VALID = 1'b0;
    checkOutput("handshake_start_ignored", int'(BUSY), 0);
    tick();
    checkOutput("idle_after_handshake", int'(BUSY), 0);

    // Illegal job sizes.
    startJob(0);
    checkOutput("err0_pulse", int'(CFG_ERR), 1);
    checkOutput("err0_busy", int'(BUSY), 0);
    tick();
    checkOutput("err0_clear", int'(CFG_ERR), 0);
    startJob(17);
    checkOutput("err17_pulse", int'(CFG_ERR), 1);
    checkOutput("err17_busy", int'(BUSY), 0);
    tick();
    checkOutput("err17_clear", int'(CFG_ERR), 0);

    // Abort by CLR mid-job, then asynchronous reset mid-job.
    startJob(4);
    sendBeat(5, 0, 0);
    sendBeat(6, 0, 0);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    checkOutput("clr_busy", int'(BUSY), 0);
    checkOutput("clr_in_ready", int'(bus.IN_READY), 0);
    checkOutput("clr_out_valid", int'(bus.OUT_VALID), 0);
    startJob(4);
    sendBeat(7, 0, 0);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("arst_busy", int'(BUSY), 0);
    checkOutput("arst_in_ready", int'(bus.IN_READY), 0);
    checkOutput("arst_out_valid", int'(bus.OUT_VALID), 0);
    checkOutput("arst_res", int'(bus.RES), 0);
    checkOutput("arst_cfg_err", int'(CFG_ERR), 0);
    tick();
    RST = 1'b0;
    tick();
    startJob(2);
    sendBeat(2, 1, 0);
    pushExpected(modelRes(-28), modelSat(-28));
    sendBeat(-9, 0, 0);
    waitIdle();
    tick();
    tick();

    checkOutput("sb_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
